// File: rtl/efx_dsp12_div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per enabled clock.
// Optional DIV0/OVFL flag ports are built when EFX_DSP12_DIV_FLAGS_EN is defined.
module efx_dsp12_div_seq #(
    parameter int W_N    = 12,
    parameter int W_D    = 4,
    parameter int SIGNED = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_N-1:0] N,
    input  logic [W_D-1:0] D,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_N-1:0] Q,
    output logic [W_D-1:0] R
`ifdef EFX_DSP12_DIV_FLAGS_EN
    ,
    output logic           DIV0,
    output logic           OVFL
`endif
);

    localparam int CW = $clog2(W_N + 1);
    localparam logic [W_N-1:0] Q_MIN = {1'b1, {(W_N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [W_N-1:0] nq;      // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [W_D-1:0] rem;
    logic [W_D-1:0] dmag;
    logic           sign_q, sign_r;

    logic           neg_n, neg_d, d_zero, q_bit;
    logic [W_N-1:0] n_abs;
    logic [W_D-1:0] d_abs, rem_nxt;
    logic [W_D:0]   sh;

    assign in_ready  = (state == S_IDLE) && CE;
    assign out_valid = (state == S_DONE);

    // The trial subtraction is a W_D+1-bit compare followed by a W_D-bit subtract:
    // a kept difference is always below |D|, so the top bit is never needed.
    always_comb begin
        neg_n   = (SIGNED != 0) && N[W_N-1];
        neg_d   = (SIGNED != 0) && D[W_D-1];
        n_abs   = neg_n ? -N : N;
        d_abs   = neg_d ? -D : D;
        d_zero  = (D == '0);
        sh      = {rem, nq[W_N-1]};
        q_bit   = (sh >= {1'b0, dmag});
        rem_nxt = q_bit ? (sh[W_D-1:0] - dmag) : sh[W_D-1:0];
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (in_valid && in_ready) state_n = d_zero ? S_DONE : S_CALC;
            S_CALC: if (CE && cnt == CW'(1)) state_n = S_FIX;
            S_FIX:  if (CE) state_n = S_DONE;
            S_DONE: if (CE && out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            nq     <= '0;
            rem    <= '0;
            dmag   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            Q      <= '0;
            R      <= '0;
        end else if (CE) begin
            case (state)
                S_IDLE: if (in_valid) begin
                    nq     <= n_abs;
                    dmag   <= d_abs;
                    sign_q <= neg_n ^ neg_d;
                    sign_r <= neg_n;
                    rem    <= '0;
                    cnt    <= CW'(W_N);
                    if (d_zero) begin
                        Q <= '1;
                        R <= '0;
                    end
                end
                S_CALC: begin
                    nq  <= {nq[W_N-2:0], q_bit};
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    Q <= sign_q ? -nq : nq;
                    R <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

`ifdef EFX_DSP12_DIV_FLAGS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            DIV0 <= 1'b0;
            OVFL <= 1'b0;
        end else if (CE) begin
            case (state)
                S_IDLE: if (in_valid && d_zero) DIV0 <= 1'b1;
                S_FIX:  OVFL <= (SIGNED != 0) && !sign_q && (nq == Q_MIN);
                S_DONE: if (out_ready) begin
                    DIV0 <= 1'b0;
                    OVFL <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_efx_dsp12_div_seq.sv
// Bench for efx_dsp12_div_seq: a signed and an unsigned instance checked against an
// integer-arithmetic reference; flag checks follow EFX_DSP12_DIV_FLAGS_EN.
module tb_efx_dsp12_div_seq;

    logic        CLK = 1'b0;
    logic        RST, CE, out_ready;
    logic [11:0] N;
    logic [3:0]  D;
    logic        s_iv, u_iv, s_ir, u_ir, s_ov, u_ov;
    logic [11:0] s_q, u_q;
    logic [3:0]  s_r, u_r;
`ifdef EFX_DSP12_DIV_FLAGS_EN
    logic        s_dz, s_of, u_dz, u_of, dz_m, of_m;
`endif
    logic        ir_m, ov_m;
    logic [11:0] q_m;
    logic [3:0]  r_m;
    bit          sel_u = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;

    efx_dsp12_div_seq #(.W_N(12), .W_D(4), .SIGNED(1)) u_s (
        .CLK(CLK), .RST(RST), .CE(CE), .in_valid(s_iv), .in_ready(s_ir),
        .N(N), .D(D), .out_valid(s_ov), .out_ready(out_ready), .Q(s_q), .R(s_r)
`ifdef EFX_DSP12_DIV_FLAGS_EN
        , .DIV0(s_dz), .OVFL(s_of)
`endif
    );

    efx_dsp12_div_seq #(.W_N(12), .W_D(4), .SIGNED(0)) u_u (
        .CLK(CLK), .RST(RST), .CE(CE), .in_valid(u_iv), .in_ready(u_ir),
        .N(N), .D(D), .out_valid(u_ov), .out_ready(out_ready), .Q(u_q), .R(u_r)
`ifdef EFX_DSP12_DIV_FLAGS_EN
        , .DIV0(u_dz), .OVFL(u_of)
`endif
    );

    assign ir_m = sel_u ? u_ir : s_ir;
    assign ov_m = sel_u ? u_ov : s_ov;
    assign q_m  = sel_u ? u_q  : s_q;
    assign r_m  = sel_u ? u_r  : s_r;
`ifdef EFX_DSP12_DIV_FLAGS_EN
    assign dz_m = sel_u ? u_dz : s_dz;
    assign of_m = sel_u ? u_of : s_of;
`endif

    // Reference: plain integer division, with the zero-divisor and overflow cases spelled out.
    task automatic ref_div(input bit sgn, input logic [11:0] n, input logic [3:0] d,
                           output logic [11:0] q, output logic [3:0] r, output bit dz, output bit ov);
        int ni, di, qi, ri;
        dz = 1'b0;
        ov = 1'b0;
        if (d == 4'd0) begin
            q  = 12'hFFF;
            r  = 4'h0;
            dz = 1'b1;
        end else if (sgn) begin
            ni = $signed(n);
            di = $signed(d);
            if (ni == -2048 && di == -1) begin
                q  = 12'h800;
                r  = 4'h0;
                ov = 1'b1;
            end else begin
                qi = ni / di;
                ri = ni % di;
                q  = qi[11:0];
                r  = ri[3:0];
            end
        end else begin
            qi = int'(n) / int'(d);
            ri = int'(n) % int'(d);
            q  = qi[11:0];
            r  = ri[3:0];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input bit uns, input logic [11:0] n, input logic [3:0] d,
                          input int hold, input int gs, input int gl, input bit noise, input string tag);
        logic [11:0] eq;
        logic [3:0]  er;
        bit          edz, eov;
        int          edges, wt, exp_lat;
        sel_u = uns;
        ref_div(!uns, n, d, eq, er, edz, eov);
        exp_lat   = (d == 4'd0) ? 0 : 13 + gl;
        out_ready = (hold == 0);
        wt = 0;
        while (ir_m !== 1'b1 && wt < 50) begin
            tick();
            wt++;
        end
        checks++;
        if (ir_m !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, ir_m);
        end
        N = n;
        D = d;
        if (uns) u_iv = 1'b1; else s_iv = 1'b1;
        tick();
        s_iv  = 1'b0;
        u_iv  = 1'b0;
        edges = 0;
        while (ov_m !== 1'b1 && edges < 100) begin
            CE = !(edges >= gs && edges < gs + gl);
            if (noise) begin
                if (uns) u_iv = 1'b1; else s_iv = 1'b1;
                N = 12'($urandom);
                D = 4'($urandom);
            end
            tick();
            edges++;
            if (edges == 1) begin
                checks++;
                if (ir_m !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_while_busy: got %b want 0", tag, ir_m);
                end
            end
        end
        CE   = 1'b1;
        s_iv = 1'b0;
        u_iv = 1'b0;
        checks++;
        if (edges !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, edges, exp_lat);
        end
        checks++;
        if (q_m !== eq || r_m !== er) begin
            errors++;
            $display("FAIL %s result N=%h D=%h: got Q=%h R=%h want Q=%h R=%h", tag, n, d, q_m, r_m, eq, er);
        end
`ifdef EFX_DSP12_DIV_FLAGS_EN
        checks++;
        if (dz_m !== edz || of_m !== eov) begin
            errors++;
            $display("FAIL %s flags: got DIV0=%b OVFL=%b want DIV0=%b OVFL=%b", tag, dz_m, of_m, edz, eov);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (ov_m !== 1'b1 || q_m !== eq || r_m !== er || ir_m !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got valid=%b Q=%h R=%h ready=%b want 1 %h %h 0",
                         tag, i, ov_m, q_m, r_m, ir_m, eq, er);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (ov_m !== 1'b0 || ir_m !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%b ready=%b want 0 1", tag, ov_m, ir_m);
        end
`ifdef EFX_DSP12_DIV_FLAGS_EN
        checks++;
        if (dz_m !== 1'b0 || of_m !== 1'b0) begin
            errors++;
            $display("FAIL %s flag_clear: got DIV0=%b OVFL=%b want 0 0", tag, dz_m, of_m);
        end
`endif
    endtask

    task automatic test_reset();
        RST = 1'b1; CE = 1'b0; out_ready = 1'b1; s_iv = 1'b0; u_iv = 1'b0; N = '0; D = '0;
        repeat (2) tick();
        RST = 1'b0; CE = 1'b1;
        tick();
        checks++;
        if (s_ir !== 1'b1 || s_ov !== 1'b0 || s_q !== 12'h0 || s_r !== 4'h0) begin
            errors++;
            $display("FAIL reset_signed: got ready=%b valid=%b Q=%h R=%h want 1 0 000 0", s_ir, s_ov, s_q, s_r);
        end
        checks++;
        if (u_ir !== 1'b1 || u_ov !== 1'b0 || u_q !== 12'h0 || u_r !== 4'h0) begin
            errors++;
            $display("FAIL reset_unsigned: got ready=%b valid=%b Q=%h R=%h want 1 0 000 0", u_ir, u_ov, u_q, u_r);
        end
    endtask

    task automatic test_signed();
        run_op(1'b0, 12'd100, 4'd7, 0, -1, 0, 1'b0, "s_100_7");
        run_op(1'b0, 12'hF9C, 4'd7, 0, -1, 0, 1'b0, "s_m100_7");
        run_op(1'b0, 12'd100, 4'h9, 0, -1, 0, 1'b0, "s_100_m7");
    endtask

    task automatic test_ovfl_div0();
        run_op(1'b0, 12'h800, 4'hF, 0, -1, 0, 1'b0, "s_ovfl");
        run_op(1'b0, 12'd55, 4'd0, 0, -1, 0, 1'b0, "s_div0");
        run_op(1'b1, 12'd55, 4'd0, 0, -1, 0, 1'b0, "u_div0");
    endtask

    task automatic test_unsigned();
        run_op(1'b1, 12'd4095, 4'd15, 0, -1, 0, 1'b0, "u_4095_15");
        run_op(1'b1, 12'd4094, 4'd15, 0, -1, 0, 1'b0, "u_4094_15");
    endtask

    task automatic test_stall();
        run_op(1'b0, 12'd100, 4'd7, 5, -1, 0, 1'b0, "hold5");
        run_op(1'b0, 12'hF9C, 4'd7, 0, 5, 3, 1'b0, "ce_gap3");
        run_op(1'b1, 12'd3000, 4'd11, 0, -1, 0, 1'b1, "busy_ignore");
    endtask

    task automatic test_rst_mid();
        sel_u = 1'b0;
        N = 12'd100; D = 4'd7; s_iv = 1'b1;
        tick();
        s_iv = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (ir_m !== 1'b1 || ov_m !== 1'b0 || q_m !== 12'h0 || r_m !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid: got ready=%b valid=%b Q=%h R=%h want 1 0 000 0", ir_m, ov_m, q_m, r_m);
        end
        run_op(1'b0, 12'd9, 4'd3, 0, -1, 0, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [11:0] n;
            logic [3:0]  d;
            bit          uns;
            uns = 1'($urandom);
            n   = 12'($urandom);
            d   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            if (i == 7) begin n = 12'h800; d = 4'hF; end
            run_op(uns, n, d, $urandom_range(0, 2), $urandom_range(0, 10), $urandom_range(0, 2),
                   1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_ovfl_div0();
        test_unsigned();
        test_stall();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
